// File: rtl/audio_pkg.sv
// Shared definitions for the audio frame feeder: frame length, controller
// states, core class codes and a saturating counter helper.
package audio_pkg;

  localparam int FRAME_LEN_DEFAULT = 512;

  localparam logic [31:0] CLASS_NORMAL      = 32'd0;
  localparam logic [31:0] CLASS_ALARM       = 32'd1;
  localparam logic [31:0] CLASS_GLASS_BREAK = 32'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_STREAM   = 3'd3,
    ST_WAIT_RES = 3'd4
  } feeder_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with occupancy counter; pushes when full and pops when
// empty are ignored, so callers may leave the requests ungated.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Full is judged on the current count only, so a full FIFO refuses a push
  // even when a pop happens in the same cycle.
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/audio_frame_feeder.sv
// Buffers host PCM samples and feeds them frame by frame, paced, to an audio
// analysis core, then captures the core's classification result.
module audio_frame_feeder
  import audio_pkg::*;
#(
  parameter int FRAME_LEN      = FRAME_LEN_DEFAULT,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] host_sample,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        feed_enable,
  input  logic [7:0]  pace_div,
  output logic        start_analysis,
  output logic [15:0] audio_sample,
  output logic        sample_valid,
  input  logic        analysis_complete,
  input  logic        audio_ai_busy,
  input  logic [31:0] audio_classification,
  input  logic [7:0]  threat_level,
  output logic        result_valid,
  output logic [31:0] result_class,
  output logic [7:0]  result_threat,
  output logic [15:0] frame_count,
  output logic [7:0]  drop_count,
  output logic        timeout_err
);

  localparam int SCW = $clog2(FRAME_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  feeder_state_t state_r, state_s;
  logic [1:0]     init_cnt_r;
  logic           armed_s;
  logic           busy_q_r;
  logic           capture_s;
  logic [7:0]     pace_lat_r, pace_lat_s;
  logic [7:0]     pace_cnt_r, pace_cnt_s;
  logic [SCW-1:0] sample_cnt_r, sample_cnt_s;
  logic [TCW-1:0] to_cnt_r, to_cnt_s;
  logic           start_s, valid_s, rv_s, terr_s, pop_s;
  logic [15:0]    sample_s, frame_s;
  logic [31:0]    class_s;
  logic [7:0]     threat_s;
  logic [15:0]    fifo_rdata;
  logic           fifo_full, fifo_empty;

  // init_cnt holds the feeder off for two cycles after reset release.
  assign armed_s    = (init_cnt_r == 2'd2);
  assign host_ready = (init_cnt_r != 2'd0) & ~fifo_full;
  assign capture_s  = busy_q_r & ~audio_ai_busy & analysis_complete;

  sample_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (host_valid & host_ready),
    .wdata (host_sample),
    .pop   (pop_s),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Post-reset arming, busy edge history and host drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt_r <= 2'd0;
      busy_q_r   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      init_cnt_r <= armed_s ? init_cnt_r : init_cnt_r + 2'd1;
      busy_q_r   <= audio_ai_busy;
      if (host_valid && !host_ready) begin
        drop_count <= sat_inc8(drop_count);
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s      = state_r;
    start_s      = 1'b0;
    valid_s      = 1'b0;
    pop_s        = 1'b0;
    sample_s     = audio_sample;
    pace_lat_s   = pace_lat_r;
    pace_cnt_s   = pace_cnt_r;
    sample_cnt_s = sample_cnt_r;
    to_cnt_s     = to_cnt_r;
    rv_s         = 1'b0;
    class_s      = result_class;
    threat_s     = result_threat;
    frame_s      = frame_count;
    terr_s       = timeout_err;
    case (state_r)
      ST_IDLE: begin
        if (feed_enable && armed_s) begin
          state_s = ST_START;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        pace_lat_s   = pace_div;
        pace_cnt_s   = 8'd0;
        sample_cnt_s = '0;
        state_s      = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_s = ST_STREAM;
      end
      ST_STREAM: begin
        if (pace_cnt_r != 8'd0) begin
          pace_cnt_s = pace_cnt_r - 8'd1;
        end else if (!fifo_empty) begin
          pop_s        = 1'b1;
          valid_s      = 1'b1;
          sample_s     = fifo_rdata;
          pace_cnt_s   = pace_lat_r;
          sample_cnt_s = sample_cnt_r + SCW'(1);
          if (sample_cnt_r == SCW'(FRAME_LEN - 1)) begin
            state_s  = ST_WAIT_RES;
            to_cnt_s = '0;
          end else begin
            state_s = ST_STREAM;
          end
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_WAIT_RES: begin
        // A capture on the final timeout cycle still wins over the timeout.
        if (capture_s) begin
          class_s  = audio_classification;
          threat_s = threat_level;
          rv_s     = 1'b1;
          frame_s  = frame_count + 16'd1;
          state_s  = ST_IDLE;
        end else if (to_cnt_r == TCW'(TIMEOUT_CYCLES - 1)) begin
          terr_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          to_cnt_s = to_cnt_r + TCW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      pace_lat_r     <= 8'd0;
      pace_cnt_r     <= 8'd0;
      sample_cnt_r   <= '0;
      to_cnt_r       <= '0;
      start_analysis <= 1'b0;
      audio_sample   <= 16'd0;
      sample_valid   <= 1'b0;
      result_valid   <= 1'b0;
      result_class   <= 32'd0;
      result_threat  <= 8'd0;
      frame_count    <= 16'd0;
      timeout_err    <= 1'b0;
    end else begin
      state_r        <= state_s;
      pace_lat_r     <= pace_lat_s;
      pace_cnt_r     <= pace_cnt_s;
      sample_cnt_r   <= sample_cnt_s;
      to_cnt_r       <= to_cnt_s;
      start_analysis <= start_s;
      audio_sample   <= sample_s;
      sample_valid   <= valid_s;
      result_valid   <= rv_s;
      result_class   <= class_s;
      result_threat  <= threat_s;
      frame_count    <= frame_s;
      timeout_err    <= terr_s;
    end
  end

endmodule

// File: tb/tb_audio_frame_feeder.sv
// Self-checking bench for audio_frame_feeder: reference queue of accepted host
// samples, a simple core model, a drop-count vector table and frame scenarios.
module tb_audio_frame_feeder;

  localparam int FRAME = 512;

  logic        clk;
  logic        rst_n;
  logic [15:0] host_sample;
  logic        host_valid;
  logic        host_ready;
  logic        feed_enable;
  logic [7:0]  pace_div;
  logic        start_analysis;
  logic [15:0] audio_sample;
  logic        sample_valid;
  logic        analysis_complete;
  logic        audio_ai_busy;
  logic [31:0] audio_classification;
  logic [7:0]  threat_level;
  logic        result_valid;
  logic [31:0] result_class;
  logic [7:0]  result_threat;
  logic [15:0] frame_count;
  logic [7:0]  drop_count;
  logic        timeout_err;

  audio_frame_feeder dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .host_sample          (host_sample),
    .host_valid           (host_valid),
    .host_ready           (host_ready),
    .feed_enable          (feed_enable),
    .pace_div             (pace_div),
    .start_analysis       (start_analysis),
    .audio_sample         (audio_sample),
    .sample_valid         (sample_valid),
    .analysis_complete    (analysis_complete),
    .audio_ai_busy        (audio_ai_busy),
    .audio_classification (audio_classification),
    .threat_level         (threat_level),
    .result_valid         (result_valid),
    .result_class         (result_class),
    .result_threat        (result_threat),
    .frame_count          (frame_count),
    .drop_count           (drop_count),
    .timeout_err          (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [7:0] exp_drop;
    logic       exp_ready;
  } drop_vec_t;

  drop_vec_t   dv [6];
  int          checks, errors;
  int          cyc, start_cnt, start_cyc, sv_in_frame, last_sv_cyc, rv_cnt, to_cyc;
  int          exp_gap, core_wait;
  int          s0, r0, rel_cyc;
  logic [15:0] first_val;
  bit          to_seen, core_respond;
  logic [15:0] exp_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {43'd0, host_ready, start_analysis, audio_sample, sample_valid, result_valid,
            result_class, result_threat, frame_count, drop_count, timeout_err};
  endfunction

  // One clock: log the push the coming edge accepts, then observe at the falling edge.
  task automatic tick();
    logic [15:0] e;
    if (rst_n && host_valid && host_ready) exp_q.push_back(host_sample);
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      sv_in_frame = 0;
      audio_ai_busy = 1'b0;
      analysis_complete = 1'b0;
      core_wait = 0;
    end else begin
      if (start_analysis) begin
        start_cnt++;
        start_cyc = cyc;
        sv_in_frame = 0;
      end
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sample_unexpected: got %0d expected none", audio_sample);
        end else begin
          e = exp_q.pop_front();
          check("sample_value", audio_sample, e);
        end
        if (sv_in_frame == 0) begin
          first_val = audio_sample;
          check("first_sample_delay_ge2", ((cyc - start_cyc) >= 2), 1);
        end else if (exp_gap != 0) begin
          check("sample_gap", cyc - last_sv_cyc, exp_gap);
        end
        last_sv_cyc = cyc;
        sv_in_frame++;
      end
      if (result_valid) rv_cnt++;
      if (timeout_err && !to_seen) begin
        to_seen = 1'b1;
        to_cyc = cyc;
      end
      if (start_analysis) begin
        audio_ai_busy = 1'b1;
        analysis_complete = 1'b0;
        core_wait = 0;
      end else if (audio_ai_busy && core_respond && sv_in_frame == FRAME) begin
        core_wait++;
        if (core_wait == 4) begin
          analysis_complete = 1'b1;
          audio_classification = 32'd2;
          threat_level = 8'd85;
          audio_ai_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic push_word(input logic [15:0] v);
    bit acc;
    acc = 1'b0;
    host_valid = 1'b1;
    host_sample = v;
    for (int b = 0; b < 3000 && !acc; b++) begin
      acc = host_ready;
      tick();
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL push_accept: value %0d got no acceptance expected acceptance", v);
    end
  endtask

  task automatic do_reset();
    host_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_outputs_zero", outs(), 128'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("host_ready_after_reset", host_ready, 1);
    check("idle_no_start_after_reset", start_analysis, 0);
  endtask

  initial begin
    dv[0] = '{10,  8'd0,   1'b1};
    dv[1] = '{6,   8'd0,   1'b0};
    dv[2] = '{1,   8'd1,   1'b0};
    dv[3] = '{100, 8'd101, 1'b0};
    dv[4] = '{154, 8'd255, 1'b0};
    dv[5] = '{20,  8'd255, 1'b0};
    checks = 0; errors = 0; cyc = 0; start_cnt = 0; start_cyc = 0; sv_in_frame = 0;
    last_sv_cyc = 0; rv_cnt = 0; to_cyc = 0; exp_gap = 0; core_wait = 0;
    to_seen = 1'b0; core_respond = 1'b0; first_val = 16'd0;
    rst_n = 1'b1; host_valid = 1'b0; host_sample = 16'd0; feed_enable = 1'b0;
    pace_div = 8'd0; analysis_complete = 1'b0; audio_ai_busy = 1'b0;
    audio_classification = 32'd0; threat_level = 8'd0;
    #2;
    do_reset();

    // Stalled FIFO (feed disabled): 16 accepted pushes then saturating drops.
    foreach (dv[k]) begin
      host_valid = 1'b1;
      for (int j = 0; j < dv[k].n; j++) begin
        host_sample = 16'($urandom);
        tick();
      end
      host_valid = 1'b0;
      check("stall_drop_count", drop_count, dv[k].exp_drop);
      check("stall_host_ready", host_ready, dv[k].exp_ready);
    end
    check("stall_no_start", start_cnt, 0);

    do_reset();

    // Ramp frame at full rate; feed_enable drops mid-frame without aborting it.
    pace_div = 8'd0; feed_enable = 1'b1; core_respond = 1'b1; exp_gap = 1;
    s0 = start_cnt; r0 = rv_cnt;
    for (int i = 0; i < FRAME; i++) begin
      push_word(16'(i));
      if (i == 200) feed_enable = 1'b0;
    end
    host_valid = 1'b0;
    for (int b = 0; b < 500 && rv_cnt == r0; b++) tick();
    check("ramp_result_class", result_class, 32'd2);
    check("ramp_result_threat", result_threat, 8'd85);
    check("ramp_frame_count", frame_count, 16'd1);
    repeat (20) tick();
    check("ramp_result_valid_pulses", rv_cnt - r0, 1);
    check("ramp_single_start", start_cnt - s0, 1);
    check("ramp_sample_count", sv_in_frame, FRAME);
    check("ramp_fifo_drained", exp_q.size(), 0);
    check("ramp_first_sample", first_val, 16'd0);

    // Paced random frame, core never answers: timeout path.
    core_respond = 1'b0; pace_div = 8'd3;
    for (int i = 0; i < 16; i++) push_word(16'($urandom));
    host_valid = 1'b0;
    exp_gap = 4; s0 = start_cnt; r0 = rv_cnt; feed_enable = 1'b1;
    for (int b = 0; b < 50 && start_cnt == s0; b++) tick();
    check("pace_frame_started", start_cnt - s0, 1);
    for (int b = 0; b < 6000 && sv_in_frame < FRAME; b++) begin
      host_valid = ($urandom_range(0, 3) != 0);
      host_sample = 16'($urandom);
      if (sv_in_frame >= 10) feed_enable = 1'b0;
      if (sv_in_frame >= 50) pace_div = 8'd0;
      tick();
    end
    host_valid = 1'b0;
    check("pace_sample_count", sv_in_frame, FRAME);
    for (int b = 0; b < 1200 && !to_seen; b++) tick();
    check("timeout_seen", to_seen, 1);
    check("timeout_delay", to_cyc - last_sv_cyc, 1024);
    repeat (50) tick();
    check("timeout_sticky", timeout_err, 1);
    check("timeout_no_result", rv_cnt - r0, 0);
    check("timeout_frame_count", frame_count, 16'd1);
    check("timeout_no_restart", start_cnt - s0, 1);

    // Reset in the middle of a stalling stream, then a fresh frame.
    exp_gap = 0; pace_div = 8'd0; core_respond = 1'b1; feed_enable = 1'b1; s0 = start_cnt;
    for (int b = 0; b < 50 && start_cnt == s0; b++) tick();
    for (int i = 0; i < 2000 && sv_in_frame < 40; i++) begin
      push_word(16'(500 + i));
      host_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    host_valid = 1'b0;
    check("pre_reset_streaming", sv_in_frame >= 40, 1);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs_zero", outs(), 128'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    rel_cyc = cyc; s0 = start_cnt; r0 = rv_cnt;
    for (int i = 0; i < FRAME; i++) begin
      push_word(16'(1000 + i));
      host_valid = 1'b0;
      if (i == 100) feed_enable = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    for (int b = 0; b < 500 && rv_cnt == r0; b++) tick();
    repeat (5) tick();
    check("restart_single_start", start_cnt - s0, 1);
    check("restart_start_delay_ge2", (start_cyc - rel_cyc) >= 2, 1);
    check("restart_first_sample", first_val, 16'd1000);
    check("restart_sample_count", sv_in_frame, FRAME);
    check("restart_result_pulses", rv_cnt - r0, 1);
    check("restart_frame_count", frame_count, 16'd1);
    check("restart_result_class", result_class, 32'd2);
    check("restart_timeout_cleared", timeout_err, 0);
    check("restart_fifo_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_frame_feeder.md
AUDIO_FRAME_FEEDER -- requirements
Module: audio_frame_feeder

Interface
REQ-001 SHALL have parameters: FRAME_LEN, default 512, samples per analysis frame; FIFO_DEPTH, default 16, sample FIFO entries (power of 2); TIMEOUT_CYCLES, default 1024, maximum wait for a result.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- host_sample  in  16  PCM sample (two's complement) from the host.
- host_valid  in  1  host_sample is offered this cycle.
- host_ready  out  1  FIFO not full; a push occurs when host_valid and host_ready are both high.
- feed_enable  in  1  permits new frames to start.
- pace_div  in  8  idle cycles inserted after each emitted sample.
- start_analysis  out  1  one-cycle pulse that opens a frame at the core.
- audio_sample  out  16  sample presented to the core.
- sample_valid  out  1  audio_sample is valid this cycle.
- analysis_complete  in  1  core result flag (level signal).
- audio_ai_busy  in  1  core busy flag.
- audio_classification  in  32  core class code.
- threat_level  in  8  core threat score.
- result_valid  out  1  one-cycle pulse; result registers updated.
- result_class  out  32  captured class code.
- result_threat  out  8  captured threat score.
- frame_count  out  16  frames completed with a result (wraps).
- drop_count  out  8  rejected host pushes (saturates at 255).
- timeout_err  out  1  sticky flag: a result wait timed out.

Function
REQ-003 SHALL buffer host samples in a FIFO_DEPTH-entry FIFO. host_ready = !full. No same-cycle full bypass: a push is refused when full, even if a pop occurs that cycle.
REQ-004 SHALL increment drop_count whenever host_valid=1 and host_ready=0, holding at 255.
REQ-005 SHALL implement the states IDLE, START, SETTLE, STREAM and WAIT_RES.
REQ-006 IDLE: SHALL move to START when feed_enable=1. It does not wait for FIFO occupancy.
REQ-007 START: SHALL drive start_analysis=1 for exactly one cycle, latch pace_div, clear the sample counter, then move to SETTLE.
REQ-008 SETTLE: SHALL hold sample_valid=0 for one cycle so that no sample coincides with the core's state change, then move to STREAM.
REQ-009 STREAM: SHALL pop one FIFO entry into registered audio_sample/sample_valid when the FIFO is non-empty and the pace counter is 0. sample_valid is high for exactly that one cycle.
REQ-010 After each emitted sample, SHALL hold sample_valid=0 for the latched pace_div cycles. pace_div=0 permits back-to-back samples.
REQ-011 An empty FIFO in STREAM SHALL stall the stream (sample_valid=0) with no error and no sample loss.
REQ-012 After the FRAME_LEN-th sample, SHALL move to WAIT_RES and clear the timeout counter.
REQ-013 WAIT_RES: SHALL capture the result on the cycle where the registered audio_ai_busy=1, the current audio_ai_busy=0 and analysis_complete=1. That capture loads result_class/result_threat, pulses result_valid on the next cycle, increments frame_count and returns to IDLE.
REQ-014 WAIT_RES: if TIMEOUT_CYCLES elapse without a capture, SHALL set timeout_err, emit no result_valid, and return to IDLE.
REQ-015 Deasserting feed_enable mid-frame SHALL NOT abort the frame. It only blocks the next IDLE->START transition.
REQ-016 pace_div changes mid-frame SHALL take effect at the next START only.
REQ-017 timeout_err SHALL clear only on reset.

Reset
REQ-018 rst_n low SHALL asynchronously force state to IDLE, empty the FIFO, and zero every output and counter: host_ready goes to 1 once rst_n releases, all other outputs to 0.
REQ-019 Reset mid-frame SHALL discard partial frame progress. The first start_analysis after release appears no earlier than 2 cycles after rst_n rises with feed_enable=1.

Structure
REQ-020 SHALL place FRAME_LEN default, the state enumeration and class-code constants (0 normal, 1 alarm/scream, 2 glass break) in shared package audio_pkg.
REQ-021 SHALL instantiate one sub-module, sample_fifo (synchronous FIFO, parameterised width/depth, full/empty flags). Control stays in audio_frame_feeder.

Verification
REQ-022 With pace_div=0, feed_enable=1 and the host pushing a ramp 0..511 continuously, the bench SHALL see one start_analysis, then 512 sample_valid pulses carrying 0..511 in order, the first pulse no earlier than 2 cycles after start_analysis.
REQ-023 With pace_div=3, the bench SHALL see consecutive sample_valid pulses exactly 4 cycles apart across the frame.
REQ-024 With host_valid held high against a stalled FIFO (feed_enable=0), the bench SHALL see 16 pushes accepted, host_ready=0, and drop_count incrementing to 255 and saturating.
REQ-025 With a core model dropping busy while analysis_complete=1, class=2 and threat=85, the bench SHALL see result_valid pulse once with result_class=2, result_threat=85 and frame_count=1.
REQ-026 With the core never dropping busy, timeout_err SHALL rise 1024 cycles after the 512th sample, with no result_valid. Reset asserted mid-STREAM SHALL zero all outputs immediately, and a new frame SHALL restart from sample 0.
